// File: rtl/au_seq_ctrl.sv
// Sequencer that runs ADD, SUB and shift-add MUL on a single shared 6-bit adder, one adder pass per clock.
// Optional build macro AU_SEQ_MUL_EN enables the multi-cycle MUL path; when it is undefined, op=10 is answered like a reserved op.
module au_seq_ctrl #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               carry_out,
  output logic               err
);
  // state | meaning
  // IDLE  | waiting for start
  // EXEC  | single adder pass for ADD/SUB
  // MUL   | shift-add iterations, one per clock
  // DONE  | done pulse, outputs valid
`ifdef AU_SEQ_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2, DONE = 2'd3} stateT;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd3} stateT;
`endif

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  stateT            state, nextState;
  logic [WIDTH-1:0] aReg, bReg;
  logic [1:0]       opReg;
  logic [WIDTH-1:0] addA, addB;
  logic             addCin;
  logic [WIDTH:0]   addTotal;
`ifdef AU_SEQ_MUL_EN
  logic [WIDTH-1:0] acc, q;
  logic [2:0]       count;
  logic             lastIter;
`endif

  // The one shared adder pass of this cycle.
  assign addTotal = {1'b0, addA} + {1'b0, addB} + {{WIDTH{1'b0}}, addCin};

  always_comb begin
    nextState = state;
    addA      = aReg;
    addB      = bReg;
    addCin    = 1'b0;
`ifdef AU_SEQ_MUL_EN
    lastIter  = (count == 3'(WIDTH - 1));
`endif
    case (state)
      IDLE: begin
        if (start) begin
          unique case (op)
            OP_ADD, OP_SUB: nextState = EXEC;
`ifdef AU_SEQ_MUL_EN
            OP_MUL:         nextState = MUL;
`else
            OP_MUL:         nextState = DONE;
`endif
            default:        nextState = DONE;
          endcase
        end
      end
      EXEC: begin
        if (opReg == OP_SUB) begin
          addB   = ~bReg;
          addCin = 1'b1;
        end
        nextState = DONE;
      end
`ifdef AU_SEQ_MUL_EN
      MUL: begin
        addA = acc;
        addB = q[0] ? aReg : '0;
        if (lastIter) nextState = DONE;
      end
`endif
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      aReg      <= '0;
      bReg      <= '0;
      opReg     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      err       <= 1'b0;
`ifdef AU_SEQ_MUL_EN
      acc       <= '0;
      q         <= '0;
      count     <= '0;
`endif
    end else begin
      state <= nextState;
      busy  <= (nextState != IDLE);
      done  <= (nextState == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            aReg  <= a;
            bReg  <= b;
            opReg <= op;
`ifdef AU_SEQ_MUL_EN
            acc   <= '0;
            q     <= b;
            count <= '0;
`endif
            // Reserved (or unbuilt) op goes straight to DONE with an error.
            if (nextState == DONE) begin
              result    <= '0;
              carry_out <= 1'b0;
              err       <= 1'b1;
            end
          end
        end
        EXEC: begin
          result    <= {{WIDTH{1'b0}}, addTotal[WIDTH-1:0]};
          carry_out <= addTotal[WIDTH];
          err       <= 1'b0;
        end
`ifdef AU_SEQ_MUL_EN
        MUL: begin
          acc   <= addTotal[WIDTH:1];
          q     <= {addTotal[0], q[WIDTH-1:1]};
          count <= count + 3'd1;
          if (lastIter) begin
            result    <= {addTotal[WIDTH:1], addTotal[0], q[WIDTH-1:1]};
            carry_out <= 1'b0;
            err       <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_au_seq_ctrl.sv
// Directed bench for au_seq_ctrl: expected results are queued when a command is issued and checked when done pulses.
// Build with +define+AU_SEQ_MUL_EN to exercise the MUL path; otherwise op=10 is expected to be rejected.
module tb_au_seq_ctrl;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [5:0]  a, b;
  logic        busy, done, carry_out, err;
  logic [11:0] result;

  int testsRun  = 0;
  int failCount = 0;

  typedef struct {
    logic [11:0] res;
    logic        cy;
    logic        er;
    int          lat;
  } expT;
  expT sbQ[$];

  au_seq_ctrl #(.WIDTH(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic expT model(input logic [1:0] o, input logic [5:0] x, input logic [5:0] y);
    expT e;
    logic [6:0] t;
    e = '{12'd0, 1'b0, 1'b1, 1};
    case (o)
      2'b00: begin
        t = {1'b0, x} + {1'b0, y};
        e = '{{6'd0, t[5:0]}, t[6], 1'b0, 2};
      end
      2'b01: begin
        t = {1'b0, x} - {1'b0, y};
        e = '{{6'd0, t[5:0]}, (x >= y), 1'b0, 2};
      end
`ifdef AU_SEQ_MUL_EN
      2'b10: e = '{12'(x * y), 1'b0, 1'b0, 7};
`endif
      default: ;
    endcase
    return e;
  endfunction

  task automatic countDones(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check(tag, seen, 0);
  endtask

  task automatic runCmd(input string tag, input logic [1:0] o, input logic [5:0] x,
                        input logic [5:0] y, input bit toggle);
    int  edges;
    expT e;
    sbQ.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); a = 6'($urandom); b = 6'($urandom);
    edges = 1;
    while (!done && edges < 30) begin
      if (toggle) start = ~start;
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 1);
    if (sbQ.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sbQ.pop_front();
      check({tag, "_latency"}, edges, e.lat);
      check({tag, "_result"}, result, e.res);
      check({tag, "_carry"}, carry_out, e.cy);
      check({tag, "_err"}, err, e.er);
    end
    @(negedge clk);
    check({tag, "_idle"}, {busy, done}, 2'b00);
    check({tag, "_hold"}, result, e.res);
    countDones({tag, "_no_extra_done"}, 3);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_result", result, 0);
    check("rst_carry", carry_out, 0);
    check("rst_err", err, 0);
    check("rst_done", done, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
    end

    runCmd("add_6_5",  2'b00, 6'd6,  6'd5, 1'b0);
    runCmd("add_60_3", 2'b00, 6'd60, 6'd3, 1'b0);
    runCmd("add_63_1", 2'b00, 6'd63, 6'd1, 1'b1);
    runCmd("sub_5_6",  2'b01, 6'd5,  6'd6, 1'b0);
    runCmd("sub_9_4",  2'b01, 6'd9,  6'd4, 1'b0);
    runCmd("rsvd_op",  2'b11, 6'd12, 6'd7, 1'b0);

`ifdef AU_SEQ_MUL_EN
    runCmd("mul_63_63", 2'b10, 6'd63, 6'd63, 1'b1);
    runCmd("mul_0_45",  2'b10, 6'd0,  6'd45, 1'b0);
    runCmd("mul_63_63b", 2'b10, 6'd63, 6'd63, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 6'd7; b = 6'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midmul_rst_busy", busy, 0);
    check("midmul_rst_done", done, 0);
    check("midmul_rst_result", result, 0);
    check("midmul_rst_carry", carry_out, 0);
    check("midmul_rst_err", err, 0);
    countDones("midmul_no_done", 10);
    runCmd("mul_7_9", 2'b10, 6'd7, 6'd9, 1'b0);
`else
    runCmd("mul_disabled", 2'b10, 6'd7, 6'd9, 1'b0);
    runCmd("add_after_rsvd", 2'b00, 6'd20, 6'd22, 1'b0);
`endif

    @(negedge clk);
    reset = 1'b1; start = 1'b1; op = 2'b00; a = 6'd1; b = 6'd2;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_start_busy", busy, 0);
    check("rst_start_result", result, 0);
    countDones("rst_start_no_done", 4);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end
endmodule
